// File: rtl/emg_stream_pkg.sv
`default_nettype none
// ============================================================================
// Package     : emg_stream_pkg
// Description : Shared types and constants for the ADC FIFO drain stream:
//               drain FSM state encoding, default header tag and the
//               stream word width.
// Revision    : 1.0 - initial release
// ============================================================================
package emg_stream_pkg;

   localparam int          WORD_W          = 16;
   localparam logic [7:0]  HDR_TAG_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2,
      ST_CHK  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/emg_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : emg_skid_buf
// Description : Two-entry valid/ready buffer. Entry 0 is the head presented
//               on the output; entry 1 holds a second word while the head
//               is stalled. The writer must never push into a full buffer,
//               so there is no input-side ready.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_in_valid/data   - push one word this cycle
//               i_out_ready       - consumer accepts head when valid
//               o_out_valid/data  - head word
//               o_occupancy       - number of stored words (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module emg_skid_buf
   import emg_stream_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_in_valid,
   input  logic [WORD_W-1:0] i_in_data,
   input  logic              i_out_ready,
   output logic              o_out_valid,
   output logic [WORD_W-1:0] o_out_data,
   output logic [1:0]        o_occupancy
);

   logic [WORD_W-1:0] e0_q, e0_d;
   logic [WORD_W-1:0] e1_q, e1_d;
   logic [1:0]        occ_q, occ_d;
   logic              pop;
   logic [1:0]        occ_after_pop;

   always_comb begin
      e0_d          = e0_q;
      e1_d          = e1_q;
      pop           = (occ_q != 2'd0) && i_out_ready;
      occ_after_pop = occ_q - {1'b0, pop};

      // Popping shifts entry 1 forward; only meaningful when it was occupied.
      if (pop) begin
         e0_d = e1_q;
      end
      // New word lands in the first free slot after the pop.
      if (i_in_valid) begin
         if (occ_after_pop == 2'd0) begin
            e0_d = i_in_data;
         end else begin
            e1_d = i_in_data;
         end
      end
      occ_d = occ_after_pop + {1'b0, i_in_valid};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         occ_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         occ_q <= occ_d;
      end
   end

   assign o_out_valid = (occ_q != 2'd0);
   assign o_out_data  = e0_q;
   assign o_occupancy = occ_q;

endmodule
`default_nettype wire

// File: rtl/adc_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : adc_fifo_drain
// Description : Read-side master for the ADC sample FIFO. Waits for a full
//               frame, pops it through the FIFO's registered read port and
//               emits header / FRAME_LEN samples / checksum under
//               valid/ready. Latches FIFO overflow/underflow as sticky flags.
// Ports       : CLK, RESET                 - clock, sync active-high reset
//               ENABLE                     - allow new frames to start
//               FIFO_EMPTY/RDCNT/Q         - FIFO status and read data
//               FIFO_OVERFLOW/UNDERFLOW    - FIFO error pulses
//               FIFO_RE                    - FIFO read strobe
//               M_DATA/VALID/READY/SOF/EOF - framed output stream
//               ERR_OVF/ERR_UNF, CLR_ERR   - sticky errors and their clear
//               FRAME_CNT                  - completed frame counter
// Revision    : 1.0 - initial release
// ============================================================================
module adc_fifo_drain
   import emg_stream_pkg::*;
#(
   parameter int         FRAME_LEN = 32,
   parameter logic [7:0] HDR_TAG   = HDR_TAG_DEFAULT
)(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ENABLE,
   input  logic              FIFO_EMPTY,
   input  logic [6:0]        FIFO_RDCNT,
   input  logic [WORD_W-1:0] FIFO_Q,
   input  logic              FIFO_OVERFLOW,
   input  logic              FIFO_UNDERFLOW,
   output logic              FIFO_RE,
   output logic [WORD_W-1:0] M_DATA,
   output logic              M_VALID,
   input  logic              M_READY,
   output logic              M_SOF,
   output logic              M_EOF,
   output logic              ERR_OVF,
   output logic              ERR_UNF,
   input  logic              CLR_ERR,
   output logic [15:0]       FRAME_CNT
);

   localparam logic [6:0] FRAME_LEN_C = 7'(FRAME_LEN);

   state_t            state_q, state_d;
   logic [15:0]       csum_q, csum_d;
   logic [7:0]        seq_q, seq_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [6:0]        issued_q, issued_d;
   logic [6:0]        sent_q, sent_d;
   logic              inflight_q, inflight_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_unf_q, err_unf_d;

   logic              buf_valid;
   logic [WORD_W-1:0] buf_data;
   logic [1:0]        buf_occ;
   logic              buf_pop;
   logic [1:0]        eff_occ;
   logic [1:0]        pending;

   // A read issued in cycle t returns on FIFO_Q in t+1 and is captured at
   // the end of t+1, so the in-flight flag is simply the previous FIFO_RE.
   emg_skid_buf u_skid (
      .clk         (CLK),
      .rst         (RESET),
      .i_in_valid  (inflight_q),
      .i_in_data   (FIFO_Q),
      .i_out_ready (buf_pop),
      .o_out_valid (buf_valid),
      .o_out_data  (buf_data),
      .o_occupancy (buf_occ)
   );

   always_comb begin
      state_d     = state_q;
      csum_d      = csum_q;
      seq_d       = seq_q;
      frame_cnt_d = frame_cnt_q;
      sent_d      = sent_q;
      M_DATA      = '0;
      M_VALID     = 1'b0;
      M_SOF       = 1'b0;
      M_EOF       = 1'b0;

      buf_pop = (state_q == ST_BODY) && buf_valid && M_READY;

      // Occupancy is counted after this cycle's pop so that a word leaving
      // the buffer frees its slot immediately; this is what allows one read
      // per cycle while the consumer keeps up, yet never overfills 2 slots.
      eff_occ = buf_occ - {1'b0, buf_pop};
      pending = eff_occ + {1'b0, inflight_q};

      // Gated by RESET so a reset cycle never consumes FIFO contents.
      FIFO_RE = !RESET && (state_q == ST_BODY) && (issued_q < FRAME_LEN_C) &&
                !FIFO_EMPTY && (pending < 2'd2);

      inflight_d = FIFO_RE;
      issued_d   = issued_q + {6'd0, FIFO_RE};

      case (state_q)
         ST_IDLE: begin
            if (ENABLE && (FIFO_RDCNT >= FRAME_LEN_C)) begin
               state_d  = ST_HDR;
               csum_d   = '0;
               issued_d = '0;
               sent_d   = '0;
            end
         end
         ST_HDR: begin
            M_DATA  = {HDR_TAG, seq_q};
            M_VALID = 1'b1;
            M_SOF   = 1'b1;
            if (M_READY) begin
               state_d = ST_BODY;
            end
         end
         ST_BODY: begin
            M_DATA  = buf_data;
            M_VALID = buf_valid;
            if (buf_pop) begin
               csum_d = csum_q + buf_data;
               sent_d = sent_q + 7'd1;
               if (sent_q == FRAME_LEN_C - 7'd1) begin
                  state_d = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            M_DATA  = csum_q;
            M_VALID = 1'b1;
            M_EOF   = 1'b1;
            if (M_READY) begin
               seq_d       = seq_q + 8'd1;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A new error event wins over a simultaneous clear.
      err_ovf_d = FIFO_OVERFLOW  | (err_ovf_q & ~CLR_ERR);
      err_unf_d = FIFO_UNDERFLOW | (err_unf_q & ~CLR_ERR);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         csum_q      <= '0;
         seq_q       <= '0;
         frame_cnt_q <= '0;
         issued_q    <= '0;
         sent_q      <= '0;
         inflight_q  <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         csum_q      <= csum_d;
         seq_q       <= seq_d;
         frame_cnt_q <= frame_cnt_d;
         issued_q    <= issued_d;
         sent_q      <= sent_d;
         inflight_q  <= inflight_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

   assign ERR_OVF   = err_ovf_q;
   assign ERR_UNF   = err_unf_q;
   assign FRAME_CNT = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_fifo_drain
// Description : Scoreboard bench for adc_fifo_drain with FRAME_LEN=4. A
//               behavioural FIFO with a registered read port feeds the DUT;
//               each frame loaded pushes its expected header, body and
//               checksum into a queue that a negedge monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_fifo_drain;

   localparam int FL = 4;

   logic        CLK = 1'b0;
   logic        RESET, ENABLE, FIFO_EMPTY, FIFO_OVERFLOW, FIFO_UNDERFLOW;
   logic [6:0]  FIFO_RDCNT;
   logic [15:0] FIFO_Q;
   logic        FIFO_RE, M_VALID, M_READY, M_SOF, M_EOF;
   logic [15:0] M_DATA, FRAME_CNT;
   logic        ERR_OVF, ERR_UNF, CLR_ERR;

   always #5 CLK = ~CLK;

   adc_fifo_drain #(.FRAME_LEN(FL), .HDR_TAG(8'hA5)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RDCNT(FIFO_RDCNT), .FIFO_Q(FIFO_Q),
      .FIFO_OVERFLOW(FIFO_OVERFLOW), .FIFO_UNDERFLOW(FIFO_UNDERFLOW),
      .FIFO_RE(FIFO_RE), .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
      .M_SOF(M_SOF), .M_EOF(M_EOF), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF),
      .CLR_ERR(CLR_ERR), .FRAME_CNT(FRAME_CNT)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- behavioural FIFO ----------------
   logic [15:0] mem [0:1023];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        fifo_flush = 1'b0;

   assign FIFO_RDCNT = 7'(wr_ptr - rd_ptr);
   assign FIFO_EMPTY = (wr_ptr == rd_ptr);

   always @(posedge CLK) begin
      if (fifo_flush) begin
         rd_ptr <= wr_ptr;
      end else if (FIFO_RE && (wr_ptr != rd_ptr)) begin
         FIFO_Q <= mem[rd_ptr % 1024];
         rd_ptr <= rd_ptr + 1;
      end
   end

   // ---------------- M_READY driver ----------------
   int rdy_mode = 1;  // 0: low, 1: high, 2: random 50%
   always @(posedge CLK) begin
      #1;
      M_READY = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
   end

   // ---------------- scoreboard monitor ----------------
   logic [17:0] exp_q [$];
   logic        mon_en = 1'b0;
   logic        quiet  = 1'b0;
   logic        stall_prev = 1'b0;
   logic [17:0] held, got, e;

   always @(negedge CLK) begin
      if (mon_en) begin
         got = {M_SOF, M_EOF, M_DATA};
         if (FIFO_RE) begin
            checks++;
            if (FIFO_EMPTY) begin
               failures++;
               $display("FAIL read_when_empty: FIFO_RE=1 with FIFO_EMPTY=1 at %0t", $time);
            end
         end
         if (quiet) begin
            checks++;
            if (M_VALID || FIFO_RE) begin
               failures++;
               $display("FAIL quiet: M_VALID=%b FIFO_RE=%b required 0/0 at %0t", M_VALID, FIFO_RE, $time);
            end
         end
         if (stall_prev) begin
            checks++;
            if (!M_VALID || got !== held) begin
               failures++;
               $display("FAIL hold: got valid=%b word=%h required valid=1 word=%h at %0t", M_VALID, got, held, $time);
            end
         end
         if (M_VALID && M_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL stream_extra: got %h with empty scoreboard at %0t", got, $time);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL stream: got sof/eof/data=%h required %h at %0t", got, e, $time);
               end
            end
         end
         stall_prev = M_VALID && !M_READY;
         held       = got;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   logic [7:0] exp_seq = 8'd0;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      mem[wr_ptr % 1024] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   // Body words taken from the low 16 bits upwards.
   task automatic expect_frame(input logic [63:0] w, input logic [15:0] csum);
      exp_q.push_back({2'b10, 8'hA5, exp_seq});
      for (int i = 0; i < FL; i++) exp_q.push_back({2'b00, w[16*i +: 16]});
      exp_q.push_back({2'b01, csum});
      exp_seq = exp_seq + 8'd1;
   endtask

   task automatic push_frame(input logic [63:0] w);
      for (int i = 0; i < FL; i++) push_word(w[16*i +: 16]);
   endtask

   task automatic wait_frames(input logic [15:0] target);
      int n = 0;
      while (FRAME_CNT !== target && n < 1000) begin
         tick();
         n++;
      end
      chk("frame_cnt_wait", {16'd0, FRAME_CNT}, {16'd0, target});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] w;
      logic [15:0] cs;
      int          n;

      RESET = 1'b1; ENABLE = 1'b0; FIFO_OVERFLOW = 1'b0; FIFO_UNDERFLOW = 1'b0;
      CLR_ERR = 1'b0;
      repeat (3) tick();
      RESET = 1'b0;
      chk("rst_valid",  {31'd0, M_VALID}, 32'd0);
      chk("rst_re",     {31'd0, FIFO_RE}, 32'd0);
      chk("rst_data",   {16'd0, M_DATA}, 32'd0);
      chk("rst_sofeof", {30'd0, M_SOF, M_EOF}, 32'd0);
      chk("rst_fcnt",   {16'd0, FRAME_CNT}, 32'd0);
      chk("rst_err",    {30'd0, ERR_OVF, ERR_UNF}, 32'd0);
      mon_en = 1'b1;
      ENABLE = 1'b1;

      // Basic frame: A500,1,2,3,4,000A
      rdy_mode = 1;
      expect_frame(64'h0004_0003_0002_0001, 16'h000A);
      push_frame(64'h0004_0003_0002_0001);
      wait_frames(16'd1);

      // Three words only: nothing may start until the fourth arrives.
      expect_frame(64'h0008_0007_0006_0005, 16'h001A);
      push_word(16'h0005); push_word(16'h0006); push_word(16'h0007);
      quiet = 1'b1;
      repeat (12) tick();
      quiet = 1'b0;
      push_word(16'h0008);
      wait_frames(16'd2);

      // ENABLE dropped mid-frame: frame finishes, next one held off.
      expect_frame(64'h0104_0103_0102_0101, 16'h040A);
      expect_frame(64'h0204_0203_0202_0201, 16'h080A);
      push_frame(64'h0104_0103_0102_0101);
      push_frame(64'h0204_0203_0202_0201);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(M_VALID && M_READY && M_SOF) && n < 100);
      tick();
      ENABLE = 1'b0;
      wait_frames(16'd3);
      quiet = 1'b1;
      repeat (12) tick();
      quiet = 1'b0;
      chk("enable_hold_fcnt", {16'd0, FRAME_CNT}, 32'd3);
      ENABLE = 1'b1;
      wait_frames(16'd4);

      // Random back-pressure, random data, until seq reaches FF.
      rdy_mode = 2;
      for (int f = 0; f < 251; f++) begin
         w  = {$urandom, $urandom};
         cs = w[15:0] + w[31:16] + w[47:32] + w[63:48];
         expect_frame(w, cs);
         push_frame(w);
         wait_frames(16'(5 + f));
         if (f == 99) chk("fcnt_after_100_random", {16'd0, FRAME_CNT}, 32'd104);
      end

      // Seq FF header with wrapping checksum, then seq wraps to 00.
      expect_frame(64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFC);
      push_frame(64'hFFFF_FFFF_FFFF_FFFF);
      wait_frames(16'd256);
      expect_frame(64'h000C_000B_000A_0009, 16'h002A);
      push_frame(64'h000C_000B_000A_0009);
      wait_frames(16'd257);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      // Reset in the middle of a body.
      rdy_mode = 1;
      expect_frame(64'h0044_0033_0022_0011, 16'h00AA);
      push_frame(64'h0044_0033_0022_0011);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(M_VALID && !M_SOF && !M_EOF) && n < 100);
      chk("reached_body", {31'd0, (M_VALID && !M_SOF && !M_EOF)}, 32'd1);
      @(posedge CLK);
      #1;
      mon_en = 1'b0;
      RESET  = 1'b1;
      tick();
      RESET  = 1'b0;
      chk("midrst_valid", {31'd0, M_VALID}, 32'd0);
      chk("midrst_re",    {31'd0, FIFO_RE}, 32'd0);
      chk("midrst_fcnt",  {16'd0, FRAME_CNT}, 32'd0);
      fifo_flush = 1'b1;
      tick();
      fifo_flush = 1'b0;
      exp_q.delete();
      exp_seq = 8'd0;
      tick();
      chk("midrst_idle_valid", {31'd0, M_VALID}, 32'd0);
      mon_en = 1'b1;

      // Sticky error flags.
      FIFO_OVERFLOW = 1'b1; CLR_ERR = 1'b1;
      tick();
      FIFO_OVERFLOW = 1'b0; CLR_ERR = 1'b0;
      chk("ovf_set_vs_clr", {31'd0, ERR_OVF}, 32'd1);
      tick();
      chk("ovf_sticky", {31'd0, ERR_OVF}, 32'd1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("ovf_cleared", {31'd0, ERR_OVF}, 32'd0);
      FIFO_UNDERFLOW = 1'b1;
      tick();
      FIFO_UNDERFLOW = 1'b0;
      chk("unf_set", {30'd0, ERR_OVF, ERR_UNF}, 32'd1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      chk("unf_cleared", {31'd0, ERR_UNF}, 32'd0);

      // First frame after reset restarts at seq 00.
      expect_frame(64'h0040_0030_0020_0010, 16'h00A0);
      push_frame(64'h0040_0030_0020_0010);
      wait_frames(16'd1);
      chk("final_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
